// File: rtl/vga_frame_capture.sv
// vga_frame_capture: sink for an hsync/vsync/video_on/pixel stream.
// Rebuilds pixel coordinates from the sync and blanking edges, writes
// active pixels to a frame-buffer port and checks the raster timing.
module vga_frame_capture #(
  parameter int HVID = 640,
  parameter int HFP  = 16,
  parameter int HS   = 96,
  parameter int HBP  = 48,
  parameter int VVID = 480,
  parameter int VFP  = 10,
  parameter int VS   = 2,
  parameter int VBP  = 29
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        video_on,
  input  logic [23:0] pixel_data,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [23:0] wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        locked,
  output logic        timing_err,
  output logic [7:0]  err_count
);

  localparam int HC_MAX = HVID + HFP + HS + HBP;
  localparam int VC_MAX = VVID + VFP + VS + VBP;

  typedef enum logic [1:0] {SEEK, IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic        hsync_q, vsync_q, von_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] lcnt_q, lcnt_d;
  logic        h_seen_q, v_seen_q, ferr_q, ferr_d;
  logic        wr_en_q, wr_en_d;
  logic [18:0] wr_addr_q, wr_addr_d;
  logic [23:0] wr_data_q;
  logic        start_q, start_d, done_q, done_d, ok_q, ok_d;
  logic        locked_q, locked_d, terr_q;
  logic [7:0]  errc_q, errc_d;

  logic        hs_rise, vs_rise, von_fall, viol;
  logic [9:0]  y_end;

  assign hs_rise  = hsync & ~hsync_q;
  assign vs_rise  = vsync & ~vsync_q;
  assign von_fall = ~video_on & von_q;
  // lines seen by the frame, including one that ends exactly on the vsync edge
  assign y_end    = y_q + {9'd0, von_fall};

  // Violation detect. Run-length checks wait for the first hsync edge so a
  // run cut short by reset is not flagged; period checks wait for a prior edge.
  always_comb begin
    viol = 1'b0;
    if (hs_rise && h_seen_q && hcnt_q != 12'(HC_MAX))                 viol = 1'b1;
    if (vs_rise && v_seen_q && lcnt_q != 11'(VC_MAX))                 viol = 1'b1;
    if (von_fall && h_seen_q && x_q != 10'(HVID))                     viol = 1'b1;
    if (vs_rise && v_seen_q && y_end != 10'(VVID))                    viol = 1'b1;
    if (video_on && vsync)                                            viol = 1'b1;
    if (video_on && (x_q >= 10'(HVID) || y_q >= 10'(VVID)))           viol = 1'b1;
  end

  // Counters, write path, lock and error bookkeeping next-state.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    ferr_d    = ferr_q | viol;
    locked_d  = locked_q;
    errc_d    = errc_q;
    if (von_fall)                        x_d = '0;
    else if (video_on && x_q != 10'h3FF) x_d = x_q + 10'd1;
    if (vs_rise)                         y_d = '0;
    else if (von_fall && y_q != 10'h3FF) y_d = y_q + 10'd1;
    if (hs_rise)                         hcnt_d = 12'd1;
    else if (hcnt_q != 12'hFFF)          hcnt_d = hcnt_q + 12'd1;
    if (vs_rise)                         lcnt_d = {10'd0, hs_rise};
    else if (hs_rise && lcnt_q != 11'h7FF) lcnt_d = lcnt_q + 11'd1;
    if (vs_rise) ferr_d = 1'b0;
    if (viol)                            locked_d = 1'b0;
    else if (vs_rise && v_seen_q && !ferr_q) locked_d = 1'b1;
    if (viol && errc_q != 8'hFF)         errc_d = errc_q + 8'd1;
    wr_en_d   = (state_q == ACTIVE) && video_on && !vsync &&
                (x_q < 10'(HVID)) && (y_q < 10'(VVID));
    wr_addr_d = 19'(y_q) * 19'(HVID) + 19'(x_q);
  end

  // Capture FSM next state; capture_en only matters on a vsync edge.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    ok_d    = 1'b0;
    if (vs_rise) begin
      if (state_q == ACTIVE) begin
        done_d = 1'b1;
        ok_d   = ~(ferr_q | viol);
      end
      if (capture_en) begin
        state_d = ACTIVE;
        start_d = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_25) begin
    if (rst) state_q <= SEEK;
    else     state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      von_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      h_seen_q  <= 1'b0;
      v_seen_q  <= 1'b0;
      ferr_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      locked_q  <= 1'b0;
      terr_q    <= 1'b0;
      errc_q    <= '0;
    end else begin
      hsync_q   <= hsync;
      vsync_q   <= vsync;
      von_q     <= video_on;
      x_q       <= x_d;
      y_q       <= y_d;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      h_seen_q  <= h_seen_q | hs_rise;
      v_seen_q  <= v_seen_q | vs_rise;
      ferr_q    <= ferr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= pixel_data;
      start_q   <= start_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      locked_q  <= locked_d;
      terr_q    <= viol;
      errc_q    <= errc_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign frame_ok    = ok_q;
  assign locked      = locked_q;
  assign timing_err  = terr_q;
  assign err_count   = errc_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a reduced 16x9 raster (8x4 active).
// Driver pushes expected writes and frame events; a negedge monitor pops them.
module tb_vga_frame_capture;
  localparam int HVID = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VVID = 4, VFP = 1, VS = 2, VBP = 2;
  localparam int HC = HVID + HFP + HS + HBP;
  localparam int VC = VVID + VFP + VS + VBP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, capture_en, hsync, vsync, video_on;
  logic [23:0] pixel_data;
  logic        wr_en, frame_start, frame_done, frame_ok, locked, timing_err;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic [7:0]  err_count;

  vga_frame_capture #(.HVID(HVID), .HFP(HFP), .HS(HS), .HBP(HBP),
                      .VVID(VVID), .VFP(VFP), .VS(VS), .VBP(VBP)) dut (
    .clk_25(clk), .rst(rst), .capture_en(capture_en), .hsync(hsync),
    .vsync(vsync), .video_on(video_on), .pixel_data(pixel_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .frame_done(frame_done), .frame_ok(frame_ok),
    .locked(locked), .timing_err(timing_err), .err_count(err_count));

  typedef struct packed { logic [18:0] addr; logic [23:0] data; } wr_t;
  typedef struct packed { logic done; logic ok; logic start; } ev_t;
  wr_t wq[$];
  ev_t eq[$];
  int  checks = 0, errors = 0, te_cnt = 0;

  // stimulus knobs (-1 = off)
  int sh_line = -1, lg_line = -1, rst_line = -1, off_line = -1, on_line = -1;
  bit inj = 0, win_err = 0, m_active = 0, prev_vs = 0, rst_pend = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // monitor: compare every write and frame event against the queues
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (wr_en) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected none", wr_addr, wr_data);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(w.addr));
        chk("wr_data", 32'(wr_data), 32'(w.data));
      end
    end
    if (frame_start || frame_done) begin
      if (eq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: got start %0b done %0b, expected none", frame_start, frame_done);
      end else begin
        e = eq.pop_front();
        chk("frame_done", 32'(frame_done), 32'(e.done));
        chk("frame_start", 32'(frame_start), 32'(e.start));
        if (e.done) chk("frame_ok", 32'(frame_ok), 32'(e.ok));
      end
    end
    if (timing_err) te_cnt++;
  end

  task automatic run_frame(input int f);
    logic vs, hs, von;
    int   len;
    ev_t  e;
    for (int l = 0; l < VC; l++) begin
      len = (l == sh_line) ? HC - 1 : HC;
      for (int hc = 0; hc < len; hc++) begin
        tick();
        if (rst_pend) begin
          rst = 1'b0; rst_pend = 0;
          chk("mid_rst wr_en", 32'(wr_en), 0);
          chk("mid_rst frame_done", 32'(frame_done), 0);
          chk("mid_rst locked", 32'(locked), 0);
          chk("mid_rst err_count", 32'(err_count), 0);
          chk("mid_rst wr_addr", 32'(wr_addr), 0);
        end
        if (hc == 0 && l == off_line) capture_en = 1'b0;
        if (hc == 0 && l == on_line)  capture_en = 1'b1;
        vs  = (l >= VVID + VFP) && (l < VVID + VFP + VS);
        hs  = (hc >= HVID + HFP) && (hc < HVID + HFP + HS);
        von = ((l < VVID) && (hc < HVID || (l == lg_line && hc == HVID))) || (inj && vs);
        if (l == sh_line || l == lg_line) win_err = 1;
        if (l == rst_line && hc == 3) begin
          rst = 1'b1; rst_pend = 1; m_active = 0;
        end
        if (vs && !prev_vs) begin
          e.done = m_active; e.ok = !win_err; e.start = capture_en;
          if (e.done || e.start) eq.push_back(e);
          m_active = capture_en;
          win_err  = 0;
        end
        if (m_active && !rst && von && !vs && l < VVID && hc < HVID)
          wq.push_back('{addr: 19'(l * HVID + hc), data: 24'(f * 4096 + l * HVID + hc)});
        hsync = hs; vsync = vs; video_on = von;
        pixel_data = 24'(f * 4096 + l * HVID + hc);
        prev_vs = vs;
      end
    end
  endtask

  int te0;

  initial begin
    rst = 1'b1; capture_en = 1'b0; hsync = 0; vsync = 0; video_on = 0; pixel_data = '0;
    repeat (3) tick();
    chk("rst wr_en", 32'(wr_en), 0);
    chk("rst wr_addr", 32'(wr_addr), 0);
    chk("rst wr_data", 32'(wr_data), 0);
    chk("rst frame_start", 32'(frame_start), 0);
    chk("rst frame_done", 32'(frame_done), 0);
    chk("rst frame_ok", 32'(frame_ok), 0);
    chk("rst locked", 32'(locked), 0);
    chk("rst timing_err", 32'(timing_err), 0);
    chk("rst err_count", 32'(err_count), 0);
    rst = 1'b0; capture_en = 1'b1;

    // clean frames; lock after the second vsync rise
    run_frame(0); run_frame(1);
    chk("locked_after_2nd_vs", 32'(locked), 1);
    chk("clean err_count", 32'(err_count), 0);
    run_frame(2); run_frame(3);

    // one short line
    te0 = te_cnt; sh_line = 2; run_frame(4); sh_line = -1;
    chk("short err_count", 32'(err_count), 1);
    chk("short te_pulses", 32'(te_cnt - te0), 1);
    chk("short locked", 32'(locked), 0);
    run_frame(5);
    chk("relock", 32'(locked), 1);

    // 9-pixel video run on line 1: x=8 dropped
    te0 = te_cnt; lg_line = 1; run_frame(6); lg_line = -1;
    chk("long err_count", 32'(err_count), 3);
    chk("long te_pulses", 32'(te_cnt - te0), 2);
    chk("long locked", 32'(locked), 0);
    run_frame(7);

    // capture_en off mid-frame, back on next frame
    off_line = 1; run_frame(8); off_line = -1;
    on_line = 1;  run_frame(9); on_line = -1;
    run_frame(10);

    // reset at line 2, capture resumes from address 0
    rst_line = 2; run_frame(11); rst_line = -1;
    chk("post_rst locked", 32'(locked), 0);
    run_frame(12);
    chk("post_rst relock", 32'(locked), 1);
    chk("post_rst err_count", 32'(err_count), 0);

    // saturate the error counter with video_on during vsync
    off_line = 1; run_frame(13); off_line = -1;
    te0 = te_cnt; inj = 1;
    for (int f = 14; f < 24; f++) run_frame(f);
    inj = 0; run_frame(24);
    chk("sat err_count", 32'(err_count), 255);
    chk("sat te_pulses_ge_300", 32'(te_cnt - te0 >= 300), 1);
    chk("sat locked", 32'(locked), 0);

    repeat (3) tick();
    chk("writes_drained", 32'(wq.size()), 0);
    chk("events_drained", 32'(eq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Sink-side counterpart of the VGA timing generator. It consumes the hsync / vsync / video_on / pixel_data stream and recovers pixel coordinates from the sync and blanking edges. It writes each active pixel into a 640x480 frame-buffer write port and checks the incoming timing against the same 800x521 raster parameters. It sits in loopback and self-test paths, capturing generator output back into memory for comparison.

## Interface
- HVID, 640, active pixels per line
- HFP, 16, horizontal front porch clocks
- HS, 96, hsync width clocks
- HBP, 48, horizontal back porch clocks
- VVID, 480, active lines per frame
- VFP, 10, vertical front porch lines
- VS, 2, vsync width lines
- VBP, 29, vertical back porch lines
- clk_25  in  1  pixel clock; sole clock
- rst  in  1  reset, synchronous, active-high
- capture_en  in  1  arm capture; sampled only at a frame boundary
- hsync  in  1  active-high horizontal sync
- vsync  in  1  active-high vertical sync
- video_on  in  1  active-region qualifier
- pixel_data  in  24  RGB pixel, valid when video_on=1
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  19  write address = y*HVID + x
- wr_data  out  24  pixel to write
- frame_start  out  1  one-cycle pulse: a captured frame begins
- frame_done  out  1  one-cycle pulse: a captured frame ends
- frame_ok  out  1  valid with frame_done; 1 means the frame had zero timing errors
- locked  out  1  timing matches parameters
- timing_err  out  1  one-cycle pulse per detected violation
- err_count  out  8  saturating violation count; cleared only by rst

## Operation
- Edge detect: hsync_q, vsync_q and von_q are registered copies of the inputs.
  - Rising edge = input & ~q.
  - Falling edge of video_on = ~video_on & von_q.
- Derived constants: HC_MAX = HVID+HFP+HS+HBP = 800; VC_MAX = VVID+VFP+VS+VBP = 521.
- FSM, three states:
  - IDLE: no writes. On a vsync rising edge with capture_en=1, go to ACTIVE and pulse frame_start.
  - ACTIVE: capture the frame. On the next vsync rising edge, pulse frame_done and set frame_ok.
    - If capture_en=1, stay in ACTIVE and pulse frame_start in the same cycle.
    - Otherwise go to IDLE.
  - SEEK: entered from rst. Waits for the first vsync rising edge, then behaves as IDLE, i.e. goes to ACTIVE if capture_en=1, else to IDLE.
- Pixel counters (10 bits each):
  - x increments on each video_on=1 cycle and clears on the video_on falling edge.
  - y increments on each video_on falling edge and clears on the vsync rising edge.
- Write: wr_en=1 when state=ACTIVE, video_on=1, x<HVID, y<VVID and vsync=0.
  - wr_addr = y*HVID + x, computed in 19 bits.
  - wr_data = pixel_data.
- Violations (each pulses timing_err and increments err_count, saturating at 255):
  - Consecutive hsync rising edges not exactly HC_MAX clocks apart.
  - Hsync rising edges between consecutive vsync rising edges not equal to VC_MAX.
  - A video_on run length not equal to HVID.
  - Active lines in a frame not equal to VVID.
  - video_on=1 while vsync=1.
- Out-of-range pixels (x>=HVID or y>=VVID) are dropped, never written, and count as a violation.
- The first hsync period and the first vsync period after rst are not checked, because they are partial.
- locked:
  - Sets at a vsync rising edge that ends a full frame with zero violations.
  - Clears in the cycle after any violation.
  - Independent of capture_en.
- capture_en changes mid-frame take effect only at the next vsync rising edge.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_start=0, frame_done=0, frame_ok=0, locked=0, timing_err=0, err_count=0. Counters=0, state=SEEK.
- Latency: an input pixel sampled at edge n appears on wr_en/wr_addr/wr_data after edge n+1. All outputs are registered.
- frame_done, frame_ok and frame_start are asserted one clock after the vsync rising edge is sampled.
- timing_err is asserted one clock after the violating edge or sample.
- A reset mid-frame discards the partial frame: no frame_done, no further writes, and the FSM returns to SEEK.
- Simultaneous events:
  - A vsync rising edge coinciding with a video_on falling edge clears y; the clear takes priority over the increment.
  - A violation in the same cycle as the frame end is counted in that frame (frame_ok=0) and also clears locked.

## Test plan
- Clean 800x521 raster with pixel = y*640+x and capture_en=1 -> 307200 writes per frame, wr_addr 0..307199 in order, wr_data matches; frame_done with frame_ok=1; locked=1 after the second vsync rise.
- One line shortened to 799 clocks -> exactly 1 timing_err from the hsync check, err_count increments by 1, locked falls, frame_ok=0 for that frame.
- capture_en deasserted mid-frame -> the current frame completes with all 307200 writes; no frame_start at the following vsync rise; state goes to IDLE.
- video_on held high for 641 clocks on line 5 -> pixel x=640 is not written, timing_err pulses, wr_addr never exceeds 5*640+639 for that line.
- rst pulsed at line 200 -> all outputs go to 0 on the next clock, no frame_done; capture resumes at the next vsync rise with wr_addr=0.
- 300 injected violations -> err_count saturates at 255.
